enc8_rr_arbiter: RTL

- Round-robin arbiter that shares one resource among eight requesters.
- Sits in the same display/encoder datapath as the 8-to-3 priority encoder. It replaces fixed highest-bit-wins priority with fair, registered arbitration that holds each grant.
- Reports the granted requester as a one-hot grant, a 3-bit index and an active-low seven-segment digit using the team's standard digit encoding.

---
 rtl/enc8_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/enc8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// enc8_rr_arbiter
//
// Round-robin arbiter sharing one resource among eight requesters. It sits in
// the display/encoder datapath in place of the fixed highest-bit-wins 8-to-3
// priority encoder. Each grant is registered and held until the holder
// releases it, withdraws its request, or reaches MAX_HOLD consecutive cycles.
// The granted requester is reported three ways: one-hot, binary index, and an
// active-low seven-segment digit.
//
// Handshake: a requester asks by holding req[i]=1. It owns the resource on
// every cycle where gnt[i]=1 (valid=1). It gives the resource back by pulsing
// done=1 or by dropping req[i]. A release edge is also the edge that hands the
// resource to the next winner, so there is no idle cycle between holders.
//
// Parameters:
//   MAX_HOLD   maximum consecutive cycles a grant may be held (legal 1..255)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         arbiter enable; 0 revokes the grant and blanks the display
//   req[7:0]   request lines, req[i]=1 means requester i wants the resource
//   done       current holder releases the resource this cycle
//   gnt[7:0]   registered one-hot grant
//   gnt_id     registered index of the granted requester (0 when no grant)
//   valid      1 while a grant is active
//   seg[6:0]   registered active-low seven-segment code, {g,f,e,d,c,b,a}
//   timeout    one-cycle pulse after a grant is force-released by MAX_HOLD
//   state_dbg  current FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module enc8_rr_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       valid,
    output logic [6:0] seg,
    output logic       timeout,
    output logic       state_dbg
);

    // Display codes that are not digits.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Hold limit expressed at the width of the hold counter.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [2:0] ptr;
    logic [2:0] ptr_nx;
    logic [7:0] hold;
    logic [7:0] hold_nx;

    logic [7:0] gnt_nx;
    logic [2:0] gnt_id_nx;
    logic       valid_nx;
    logic [6:0] seg_nx;
    logic       timeout_nx;

    // Arbitration result.
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    // Release qualifiers for the current holder.
    logic       holder_req;
    logic       hold_max;
    logic       release_now;
    logic       forced_release;

    // -------------------------------------------------------------------------
    // Seven-segment digit lookup for a requester index.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] digit_seg(input logic [2:0] idx);
        logic [6:0] code;
        case (idx)
            3'd0:    code = 7'b1000000;
            3'd1:    code = 7'b1111001;
            3'd2:    code = 7'b0100100;
            3'd3:    code = 7'b0110000;
            3'd4:    code = 7'b0011001;
            3'd5:    code = 7'b0010010;
            3'd6:    code = 7'b0000010;
            default: code = 7'b1111000;
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin scan. Candidates are visited from the farthest position
    // (ptr itself) down to the nearest (ptr+1), so the last write that hits
    // is the closest set bit after ptr. ptr is always the last holder (or 7
    // after reset), so the last holder ends up with the lowest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Release decision for the holder. A timeout is flagged only when the
    // hold limit is the sole reason; an explicit done or a withdrawal on the
    // same edge counts as a normal release.
    // -------------------------------------------------------------------------
    always_comb begin
        holder_req     = req[gnt_id];
        hold_max       = (hold == HOLD_LIMIT);
        release_now    = done || !holder_req || hold_max;
        forced_release = !done && holder_req && hold_max;
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        hold_nx    = hold;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        valid_nx   = valid;
        seg_nx     = seg;
        timeout_nx = 1'b0;

        if (!en) begin
            // Disable overrides everything but reset; ptr is kept so fairness
            // resumes where it left off.
            state_nx  = IDLE;
            hold_nx   = 8'd0;
            gnt_nx    = 8'd0;
            gnt_id_nx = 3'd0;
            valid_nx  = 1'b0;
            seg_nx    = SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state_nx  = GRANT;
                        ptr_nx    = win_idx;
                        hold_nx   = 8'd1;
                        gnt_nx    = 8'b1 << win_idx;
                        gnt_id_nx = win_idx;
                        valid_nx  = 1'b1;
                        seg_nx    = digit_seg(win_idx);
                    end else begin
                        hold_nx   = 8'd0;
                        gnt_nx    = 8'd0;
                        gnt_id_nx = 3'd0;
                        valid_nx  = 1'b0;
                        seg_nx    = SEG_DASH;
                    end
                end

                GRANT: begin
                    if (release_now) begin
                        timeout_nx = forced_release;
                        if (win_found) begin
                            // Back-to-back handoff; the scan already starts
                            // after the current holder, which may win again
                            // if it is the only requester left.
                            state_nx  = GRANT;
                            ptr_nx    = win_idx;
                            hold_nx   = 8'd1;
                            gnt_nx    = 8'b1 << win_idx;
                            gnt_id_nx = win_idx;
                            valid_nx  = 1'b1;
                            seg_nx    = digit_seg(win_idx);
                        end else begin
                            state_nx  = IDLE;
                            hold_nx   = 8'd0;
                            gnt_nx    = 8'd0;
                            gnt_id_nx = 3'd0;
                            valid_nx  = 1'b0;
                            seg_nx    = SEG_DASH;
                        end
                    end else begin
                        // hold < HOLD_LIMIT <= 255 here, so no wrap.
                        hold_nx = hold + 8'd1;
                    end
                end

                default: begin
                    state_nx  = IDLE;
                    hold_nx   = 8'd0;
                    gnt_nx    = 8'd0;
                    gnt_id_nx = 3'd0;
                    valid_nx  = 1'b0;
                    seg_nx    = SEG_DASH;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers. ptr resets to 7 so requester 0 is scanned
    // first after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd7;
            hold    <= 8'd0;
            gnt     <= 8'd0;
            gnt_id  <= 3'd0;
            valid   <= 1'b0;
            seg     <= SEG_BLANK;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            hold    <= hold_nx;
            gnt     <= gnt_nx;
            gnt_id  <= gnt_id_nx;
            valid   <= valid_nx;
            seg     <= seg_nx;
            timeout <= timeout_nx;
        end
    end

    assign state_dbg = (state == GRANT);

endmodule
